midi_msg_tx: RTL and testbench

//  MIDI OUT message transmitter: the transmit end of the synthesizer's MIDI UART link (drives midi_txd).

---
 rtl/midi_msg_tx_pkg.sv | 45 ++++
 rtl/midi_msg_tx_if.sv | 18 +
 rtl/midi_msg_tx_uart_tx_byte.sv | 73 +++++++
 rtl/midi_msg_tx.sv | 104 ++++++++++
 tb/tb_midi_msg_tx.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/midi_msg_tx_pkg.sv
// Shared MIDI definitions for the transmit path: status constants and the
// helpers that classify a status byte and derive the length of its message.
package holosynth_midi_pkg;

   localparam logic [7:0] NOTE_OFF   = 8'h80;
   localparam logic [7:0] NOTE_ON    = 8'h90;
   localparam logic [7:0] PROG_CHG   = 8'hC0;
   localparam logic [7:0] PITCH_BEND = 8'hE0;
   localparam logic [7:0] SYSEX      = 8'hF0;
   localparam logic [7:0] MTC_QF     = 8'hF1;
   localparam logic [7:0] SONG_POS   = 8'hF2;
   localparam logic [7:0] SONG_SEL   = 8'hF3;
   localparam logic [7:0] TUNE_REQ   = 8'hF6;
   localparam logic [7:0] CLOCK      = 8'hF8;

   // Total bytes on the line for a message, status byte included.
   function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
      logic [1:0] len;
      if (status < NOTE_OFF)
         len = 2'd1;
      else if (status < PROG_CHG)
         len = 2'd3;
      else if (status < PITCH_BEND)
         len = 2'd2;
      else if (status < SYSEX)
         len = 2'd3;
      else if (status == MTC_QF || status == SONG_SEL)
         len = 2'd2;
      else if (status == SONG_POS)
         len = 2'd3;
      else
         len = 2'd1;
      return len;
   endfunction

   function automatic logic is_channel_msg(input logic [7:0] status);
      return (status >= NOTE_OFF) && (status < SYSEX);
   endfunction

   // System common and SysEx framing bytes break running status; realtime does not.
   function automatic logic is_system_common(input logic [7:0] status);
      return (status >= SYSEX) && (status < CLOCK);
   endfunction

endpackage

// File: rtl/midi_msg_tx_if.sv
// Message handshake between a MIDI message producer and the transmitter.
interface midi_msg_tx_if;
   logic       msg_valid;
   logic       msg_ready;
   logic [7:0] msg_status;
   logic [7:0] msg_data1;
   logic [7:0] msg_data2;

   modport master (
      output msg_valid, msg_status, msg_data1, msg_data2,
      input  msg_ready
   );

   modport slave (
      input  msg_valid, msg_status, msg_data1, msg_data2,
      output msg_ready
   );
endinterface

// File: rtl/midi_msg_tx_uart_tx_byte.sv
// One 8N1 UART frame per start pulse. A new start may be taken on the final
// stop tick so consecutive frames run back to back.
module midi_uart_tx_byte #(
   parameter int BIT_TICKS = 1600
) (
   input  logic       reg_clk,
   input  logic       reset_reg,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       txd,
   output logic       done
);

   localparam int TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    state;
   logic [TW-1:0] tick;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          tick_end;

   assign tick_end = (tick == TW'(BIT_TICKS - 1));
   assign done     = (state == S_STOP) && tick_end;

   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         state   <= S_IDLE;
         tick    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         txd     <= 1'b1;
      end else if (start && (state == S_IDLE || done)) begin
         state   <= S_START;
         tick    <= '0;
         bit_idx <= '0;
         shift   <= tx_byte;
         txd     <= 1'b0;
      end else if (state != S_IDLE) begin
         if (!tick_end) begin
            tick <= tick + TW'(1);
         end else begin
            tick <= '0;
            case (state)
               S_START: begin
                  state <= S_DATA;
                  txd   <= shift[0];
                  shift <= shift >> 1;
               end
               S_DATA: begin
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shift[0];
                     shift   <= shift >> 1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  txd   <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI OUT message transmitter: takes whole messages, drops repeated channel
// status bytes when running status is enabled, and streams 8N1 frames.
module midi_msg_tx
   import holosynth_midi_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int BAUD           = 31250,
   parameter int RUNNING_STATUS = 1
) (
   input  logic          reg_clk,
   input  logic          reset_reg,
   midi_msg_tx_if.slave  msg,
   output logic          midi_txd,
   output logic          busy
);

   localparam int BIT_TICKS = CLK_HZ / BAUD;

   localparam logic [0:0] SEQ_IDLE = 1'b0;
   localparam logic [0:0] SEQ_SEND = 1'b1;

   logic [0:0] seq_state;
   logic [7:0] rs_status;
   logic       rs_valid;
   logic [7:0] next_byte;
   logic [7:0] after_byte;
   logic [1:0] remaining;

   logic       accept;
   logic       acc_skip;
   logic [1:0] acc_len;
   logic       start_frame;
   logic [7:0] frame_byte;
   logic       frame_done;

   assign msg.msg_ready = (seq_state == SEQ_IDLE);
   assign busy          = ~msg.msg_ready;

   // The first frame is launched on the accept edge itself so the start bit
   // appears on the very next cycle; later frames chain off the stop tick.
   always_comb begin
      acc_len     = midi_msg_len(msg.msg_status);
      acc_skip    = (RUNNING_STATUS != 0) && is_channel_msg(msg.msg_status)
                    && rs_valid && (rs_status == msg.msg_status);
      accept      = msg.msg_valid && msg.msg_ready;
      start_frame = 1'b0;
      frame_byte  = '0;
      if (accept) begin
         start_frame = 1'b1;
         frame_byte  = acc_skip ? {1'b0, msg.msg_data1[6:0]} : msg.msg_status;
      end else if (frame_done && remaining != 2'd0) begin
         start_frame = 1'b1;
         frame_byte  = next_byte;
      end
   end

   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         seq_state  <= SEQ_IDLE;
         rs_status  <= '0;
         rs_valid   <= 1'b0;
         next_byte  <= '0;
         after_byte <= '0;
         remaining  <= '0;
      end else if (accept) begin
         seq_state <= SEQ_SEND;
         remaining <= acc_len - 2'd1 - {1'b0, acc_skip};
         if (acc_skip) begin
            next_byte  <= {1'b0, msg.msg_data2[6:0]};
            after_byte <= '0;
         end else begin
            next_byte  <= {1'b0, msg.msg_data1[6:0]};
            after_byte <= {1'b0, msg.msg_data2[6:0]};
         end
         if (RUNNING_STATUS != 0) begin
            if (is_channel_msg(msg.msg_status)) begin
               rs_status <= msg.msg_status;
               rs_valid  <= 1'b1;
            end else if (is_system_common(msg.msg_status)) begin
               rs_valid <= 1'b0;
            end
         end
      end else if (frame_done) begin
         if (remaining != 2'd0) begin
            remaining <= remaining - 2'd1;
            next_byte <= after_byte;
         end else begin
            seq_state <= SEQ_IDLE;
         end
      end
   end

   midi_uart_tx_byte #(
      .BIT_TICKS (BIT_TICKS)
   ) u_uart (
      .reg_clk   (reg_clk),
      .reset_reg (reset_reg),
      .start     (start_frame),
      .tx_byte   (frame_byte),
      .txd       (midi_txd),
      .done      (frame_done)
   );

endmodule

// File: tb/tb_midi_msg_tx.sv
// Bench for midi_msg_tx: one instance without and one with running status,
// both at four clocks per bit, with a line decoder on each serial output.
module tb_midi_msg_tx;
   import holosynth_midi_pkg::*;

   localparam int BT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic txd0, txd1, busy0, busy1;
   logic [1:0] txd_vec;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] q0[$], q1[$], e0[$], e1[$];
   int mrs[2];
   int mon_cnt[2];
   logic [7:0] mon_byte[2];

   midi_msg_tx_if if0 ();
   midi_msg_tx_if if1 ();

   midi_msg_tx #(.CLK_HZ(BT * 31250), .BAUD(31250), .RUNNING_STATUS(0)) dut0 (
      .reg_clk(clk), .reset_reg(rst), .msg(if0), .midi_txd(txd0), .busy(busy0));

   midi_msg_tx #(.CLK_HZ(BT * 31250), .BAUD(31250), .RUNNING_STATUS(1)) dut1 (
      .reg_clk(clk), .reset_reg(rst), .msg(if1), .midi_txd(txd1), .busy(busy1));

   assign txd_vec = {txd1, txd0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [7:0]       s;
      logic [7:0]       d1;
      logic [7:0]       d2;
      int               n;
      logic [2:0][7:0]  e;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Line decoder: sample mid-bit, check the stop bit, abandon the frame on reset.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mon_cnt[k] = 0;
         end else if (mon_cnt[k] == 0) begin
            if (!txd_vec[k]) mon_cnt[k] = 1;
         end else begin
            if (mon_cnt[k] >= 6 && mon_cnt[k] <= 34 && (mon_cnt[k] % 4) == 2)
               mon_byte[k][3'((mon_cnt[k] - 6) / 4)] = txd_vec[k];
            if (mon_cnt[k] == 38) begin
               check($sformatf("stop_bit%0d", k), 32'(txd_vec[k]), 32'd1);
               if (k == 0) q0.push_back(mon_byte[k]);
               else        q1.push_back(mon_byte[k]);
            end
            mon_cnt[k] = (mon_cnt[k] == 39) ? 0 : mon_cnt[k] + 1;
         end
      end
   end

   function automatic logic rdy(input int k);
      return (k == 0) ? if0.msg_ready : if1.msg_ready;
   endfunction

   function automatic logic bsy(input int k);
      return (k == 0) ? busy0 : busy1;
   endfunction

   task automatic drive(input int k, input logic v, input logic [7:0] s, d1, d2);
      if (k == 0) begin
         if0.msg_valid = v; if0.msg_status = s; if0.msg_data1 = d1; if0.msg_data2 = d2;
      end else begin
         if1.msg_valid = v; if1.msg_status = s; if1.msg_data1 = d1; if1.msg_data2 = d2;
      end
   endtask

   // Behavioural reference: bytes the line should carry for one message.
   function automatic int ref_len(input logic [7:0] s);
      if (!s[7]) return 1;
      case (s[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 3;
         4'hC, 4'hD: return 2;
         default: return (s == 8'hF2) ? 3 : ((s == 8'hF1 || s == 8'hF3) ? 2 : 1);
      endcase
   endfunction

   task automatic model_msg(input int k, input logic [7:0] s, d1, d2);
      int  n;
      bit  chan;
      bit  send_status;
      logic [7:0] out[$];
      n           = ref_len(s);
      chan        = (s >= 8'h80 && s <= 8'hEF);
      send_status = !(k == 1 && chan && mrs[k] == int'(s));
      if (k == 1) begin
         if (chan) mrs[k] = int'(s);
         else if (s >= 8'hF0 && s <= 8'hF7) mrs[k] = -1;
      end
      if (send_status) out.push_back(s);
      if (n >= 2) out.push_back(d1 & 8'h7F);
      if (n == 3) out.push_back(d2 & 8'h7F);
      foreach (out[i]) begin
         if (k == 0) e0.push_back(out[i]);
         else        e1.push_back(out[i]);
      end
   endtask

   task automatic send_msg(input int k, input logic [7:0] s, d1, d2, output int acc);
      int w;
      w = 0;
      drive(k, 1'b1, s, d1, d2);
      while (!rdy(k) && w < 2000) begin
         @(posedge clk); #1; w++;
      end
      check($sformatf("ready_wait%0d", k), 32'(w < 2000), 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      drive(k, 1'b0, 8'h00, 8'h00, 8'h00);
      check($sformatf("start_bit%0d", k), 32'(txd_vec[k]), 32'd0);
   endtask

   task automatic wait_idle(input int k, output int n);
      n = 0;
      while (bsy(k) && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      check($sformatf("idle_wait%0d", k), 32'(n < 5000), 32'd1);
   endtask

   task automatic check_line(input int k, input string name);
      int na, ne;
      na = (k == 0) ? q0.size() : q1.size();
      ne = (k == 0) ? e0.size() : e1.size();
      check({name, "_len"}, 32'(na), 32'(ne));
      for (int i = 0; i < ne; i++) begin
         logic [31:0] a, x;
         if (k == 0) begin
            a = (i < na) ? 32'(q0[i]) : 32'hFFFF_FFFF;
            x = 32'(e0[i]);
         end else begin
            a = (i < na) ? 32'(q1[i]) : 32'hFFFF_FFFF;
            x = 32'(e1[i]);
         end
         check($sformatf("%s_b%0d", name, i), a, x);
      end
      if (k == 0) begin q0.delete(); e0.delete(); end
      else        begin q1.delete(); e1.delete(); end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      q0.delete(); q1.delete(); e0.delete(); e1.delete();
      mrs[0] = -1; mrs[1] = -1;
   endtask

   task automatic rand_run(input int k, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         logic [7:0] s, d1, d2;
         int sel, acc;
         sel = $urandom_range(0, 9);
         if (sel < 6)       s = {1'b1, 3'($urandom_range(0, 6)), 4'($urandom_range(0, 1))};
         else if (sel == 6) s = CLOCK;
         else if (sel == 7) s = {4'hF, 4'($urandom_range(0, 7))};
         else if (sel == 8) s = {1'b0, 7'($urandom)};
         else               s = 8'($urandom);
         d1 = 8'($urandom);
         d2 = 8'($urandom);
         model_msg(k, s, d1, d2);
         send_msg(k, s, d1, d2, acc);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] s, d1, d2, input int n,
                               input logic [7:0] x0, x1, x2);
      vec_t v;
      v.s = s; v.d1 = d1; v.d2 = d2; v.n = n;
      v.e[0] = x0; v.e[1] = x1; v.e[2] = x2;
      return v;
   endfunction

   initial begin
      int a1, a2, n;
      drive(0, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1, 1'b0, 8'h00, 8'h00, 8'h00);

      vecs[0]  = mk(8'hC5, 8'h07, 8'h00, 2, 8'hC5, 8'h07, 8'h00);
      vecs[1]  = mk(8'hF8, 8'h11, 8'h22, 1, 8'hF8, 8'h00, 8'h00);
      vecs[2]  = mk(8'hC5, 8'h08, 8'h00, 1, 8'h08, 8'h00, 8'h00);
      vecs[3]  = mk(8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);
      vecs[4]  = mk(8'hF2, 8'h10, 8'h20, 3, 8'hF2, 8'h10, 8'h20);
      vecs[5]  = mk(8'h90, 8'h3C, 8'h00, 3, 8'h90, 8'h3C, 8'h00);
      vecs[6]  = mk(8'h80, 8'hFF, 8'hC1, 3, 8'h80, 8'h7F, 8'h41);
      vecs[7]  = mk(8'h55, 8'h12, 8'h34, 1, 8'h55, 8'h00, 8'h00);
      vecs[8]  = mk(8'h80, 8'h01, 8'h02, 2, 8'h01, 8'h02, 8'h00);
      vecs[9]  = mk(8'hF6, 8'h01, 8'h02, 1, 8'hF6, 8'h00, 8'h00);
      vecs[10] = mk(8'h80, 8'h01, 8'h02, 3, 8'h80, 8'h01, 8'h02);

      do_reset();
      check("rst_ready0", 32'(if0.msg_ready), 32'd1);
      check("rst_ready1", 32'(if1.msg_ready), 32'd1);
      check("rst_txd0",   32'(txd0),  32'd1);
      check("rst_txd1",   32'(txd1),  32'd1);
      check("rst_busy0",  32'(busy0), 32'd0);
      check("rst_busy1",  32'(busy1), 32'd0);

      // Plain note-on without running status.
      model_msg(0, NOTE_ON, 8'h3C, 8'h64);
      send_msg(0, NOTE_ON, 8'h3C, 8'h64, a1);
      wait_idle(0, n);
      check("t1_busy_cycles", 32'(n), 32'(3 * 10 * BT));
      repeat (3) begin @(posedge clk); #1; end
      check_line(0, "t1");

      // Held valid: second message goes out on the ready rise, status dropped.
      do_reset();
      model_msg(1, 8'h90, 8'h3C, 8'h64);
      send_msg(1, 8'h90, 8'h3C, 8'h64, a1);
      model_msg(1, 8'h90, 8'h40, 8'h00);
      send_msg(1, 8'h90, 8'h40, 8'h00, a2);
      check("t2_accept_gap", 32'(a2 - a1), 32'(3 * 10 * BT + 1));
      wait_idle(1, n);
      check("t2_busy_cycles", 32'(n), 32'(2 * 10 * BT));
      repeat (3) begin @(posedge clk); #1; end
      check_line(1, "t2");

      // Table of running-status and masking cases on the compressing instance.
      do_reset();
      for (int v = 0; v < 11; v++) begin
         send_msg(1, vecs[v].s, vecs[v].d1, vecs[v].d2, a1);
         wait_idle(1, n);
         check($sformatf("vec%0d_busy", v), 32'(n), 32'(vecs[v].n * 10 * BT));
         check($sformatf("vec%0d_len", v), 32'(q1.size()), 32'(vecs[v].n));
         for (int i = 0; i < vecs[v].n; i++)
            check($sformatf("vec%0d_b%0d", v, i),
                  (i < q1.size()) ? 32'(q1[i]) : 32'hFFFF_FFFF, 32'(vecs[v].e[i]));
         q1.delete();
      end

      // Reset during bit 3 of the second data byte.
      do_reset();
      send_msg(1, 8'h90, 8'h3C, 8'h64, a1);
      repeat (97) begin @(posedge clk); #1; end
      check("t5_bit3_level", 32'(txd1), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t5_txd",   32'(txd1), 32'd1);
      check("t5_ready", 32'(if1.msg_ready), 32'd1);
      check("t5_busy",  32'(busy1), 32'd0);
      rst = 1'b0;
      q1.delete(); e1.delete(); mrs[1] = -1;
      repeat (3) begin @(posedge clk); #1; end
      model_msg(1, 8'h90, 8'h3C, 8'h64);
      send_msg(1, 8'h90, 8'h3C, 8'h64, a1);
      wait_idle(1, n);
      repeat (3) begin @(posedge clk); #1; end
      check_line(1, "t5");

      // Randomised traffic on both instances against the reference model.
      do_reset();
      fork
         begin : r0
            int n0;
            rand_run(0, 30);
            wait_idle(0, n0);
         end
         begin : r1
            int n1;
            rand_run(1, 30);
            wait_idle(1, n1);
         end
      join
      repeat (3) begin @(posedge clk); #1; end
      check_line(0, "rand0");
      check_line(1, "rand1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
